alu_rs_pipe: RTL and testbench
==============================

# alu_rs_pipe

Parametrised ALU reservation station with integrated single-stage execute and registered result. It sits between the decoder and the ALU CDB arbiter. Compared with the earlier ALU station it adds:
- any depth, data width and tag width;
- wakeup from several CDB ports at once;
- oldest-first issue;
- a per-entry PC;
- a valid/ready result handshake;
- flush.

## Interface
- DATA_W, 32, operand/result/PC width
- TAG_W, 5, rename tag width; tag 0 means "operand present"
- DEPTH, 8, station entries (≥2)
- NCDB, 2, number of CDB snoop ports
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all entries and the output register
- in_valid  in  1  decoder dispatch request
- in_ready  out  1  count < DEPTH (combinational from registered count)
- in_op  in  4  0 NOP, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 SLTU, 6 XOR, 7 SRL, 8 SRA, 9 OR, 10 AND, 11 LUI, 12 JAL, 13 JALR; 14–15 treated as NOP
- in_dest  in  TAG_W  result tag
- in_tag1 / in_tag2  in  TAG_W  operand tags
- in_data1 / in_data2  in  DATA_W  operand values, meaningful when the matching tag is 0
- in_pc  in  DATA_W  instruction PC
- cdb_valid  in  NCDB  per-port broadcast valid
- cdb_tag  in  NCDB*TAG_W  port p occupies bits [p*TAG_W +: TAG_W]
- cdb_data  in  NCDB*DATA_W  port p occupies bits [p*DATA_W +: DATA_W]
- out_valid  out  1  result register holds a result
- out_ready  in  1  arbiter accepts the result
- out_tag  out  TAG_W  dest tag of the result
- out_data  out  DATA_W  result value
- out_target  out  DATA_W  jump target, JAL/JALR only
- out_pc_valid  out  1  result is a jump
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
**Dispatch**
- Accepted when in_valid && in_ready && !flush && in_op is not NOP.
- A NOP dispatch is dropped and does not change count.
- The instruction is written to the lowest-index free entry.
- Its age is recorded in an age matrix: the new entry is younger than all others.

**Dispatch bypass**
- If an incoming tag is non-zero and equals a valid cdb_tag in the same cycle, that operand is stored as present with the CDB data.

**Wakeup**
- Every cycle, each occupied entry compares tag1 and tag2 against all valid CDB ports.
- On a match with a non-zero tag, the entry latches the data and clears the tag to 0.
- If several ports match, the lowest port index wins.

**Ready and issue**
- Ready = occupied && tag1==0 && tag2==0.
- Issue slot open = !out_valid || out_ready.
- When the slot is open and at least one entry is ready, the oldest ready entry issues at the clock edge.
- Issuing computes the result into the output register and frees the entry in the same edge.
- An entry dispatched or woken in cycle t is first eligible in cycle t+1; there is no same-cycle dispatch→issue path.

**Execute** (all arithmetic modulo 2^DATA_W)
- ADD/SUB/XOR/OR/AND: as named.
- SLT: signed compare; SLTU: unsigned compare.
- SLL/SRL/SRA: shift amount is data2[$clog2(DATA_W)-1:0]; SRA sign-fills.
- LUI: data = data2.
- JAL: target = data1+data2; data = pc+4; out_pc_valid = 1.
- JALR: target = (data1+data2) & ~1; data = pc+4, using the entry's own pc; out_pc_valid = 1.
- Non-jump ops: out_target = 0 and out_pc_valid = 0.

**Output register**
- Holds its value while out_valid && !out_ready.
- When accepted and no issue happens in the same cycle, it clears: out_valid=0 and all fields 0.

**Count**
- count += dispatch − issue; a simultaneous dispatch and issue leaves count unchanged.
- At DEPTH, in_ready=0. A dispatch at full is ignored, even if an issue frees an entry in the same cycle.

**Flush**
- Takes priority over dispatch, wakeup and issue.
- Next state: all entries free, count=0, age matrix cleared, out_valid=0.

**Reset** (rst low, asynchronous)
- All entries free, count=0.
- out_valid=0, out_tag=0, out_data=0, out_target=0, out_pc_valid=0.
- in_ready=1 once count=0.
- Reset asserted mid-operation discards all contents immediately.

## Timing
- Dispatch with both operands present at edge t → out_valid high after edge t+1 (2-edge latency), provided the slot is open.
- CDB wakeup at edge t → issue at edge t+1 at the earliest.
- A backpressured result (out_ready=0) blocks further issue; entries keep waking up.
- Back-to-back issue every cycle while out_ready=1.

## Test plan
- **Reset and simple ADD.** Reset; dispatch ADD, data1=5, data2=7, dest=3, tags 0 → two edges later out_valid=1, out_tag=3, out_data=12, out_pc_valid=0; in_ready=1 throughout.
- **Multi-port wakeup.** Dispatch SUB with tag1=4, tag2=6, DEPTH=8, NCDB=2. Drive port0 tag4=100 and port1 tag6=30 in the same cycle → next edge issues, out_data=70. Repeat with both ports carrying tag 4, values 9 and 8 → port0 wins, data1=9.
- **Oldest-first and fill/full.** Fill 8 entries where entry 7 (youngest) is ready and entries 0–6 wait. Then wake entries 2 and 5 together → entry 7 issues first, then 2, then 5. At count=8, in_ready=0 and a dispatch attempt leaves count=8.
- **Backpressure.** Hold out_ready=0 with 3 ready entries → out_valid stays 1, out_data stable, count stays 3. Release → three results on consecutive cycles.
- **Jumps and shifts.** JALR, data1=0x1001, data2=4, pc=0x200 → out_target=0x1004, out_data=0x204, out_pc_valid=1. SRA with data1=0x80000000, data2=0x21 → out_data=0xC0000000.
- **Flush and reset.** Flush with 5 entries and a held result → next cycle count=0, out_valid=0. Assert rst low between edges → outputs clear immediately, without waiting for an edge.

Source files
------------

// File: rtl/alu_rs_pipe.sv
// ALU reservation station: multi-port CDB wakeup, oldest-first issue, one-stage execute into a result register.
// Latency: dispatch to out_valid is 2 edges. A held result (out_valid && !out_ready) stalls issue, but entries keep waking.
module alu_rs_pipe #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5,
    parameter int DEPTH  = 8,
    parameter int NCDB   = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int IW    = $clog2(DEPTH),
    localparam int SW    = $clog2(DATA_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [TAG_W-1:0]       in_dest,
    input  logic [TAG_W-1:0]       in_tag1,
    input  logic [TAG_W-1:0]       in_tag2,
    input  logic [DATA_W-1:0]      in_data1,
    input  logic [DATA_W-1:0]      in_data2,
    input  logic [DATA_W-1:0]      in_pc,
    input  logic [NCDB-1:0]        cdb_valid,
    input  logic [NCDB*TAG_W-1:0]  cdb_tag,
    input  logic [NCDB*DATA_W-1:0] cdb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAG_W-1:0]       out_tag,
    output logic [DATA_W-1:0]      out_data,
    output logic [DATA_W-1:0]      out_target,
    output logic                   out_pc_valid,
    output logic [CW-1:0]          count
);
    localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_SLL = 4'd3, OP_SLT = 4'd4,
                           OP_SLTU = 4'd5, OP_XOR = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8,
                           OP_OR = 4'd9, OP_AND = 4'd10, OP_LUI = 4'd11, OP_JAL = 4'd12,
                           OP_JALR = 4'd13;

    logic [DEPTH-1:0]  occ;
    logic [DEPTH-1:0]  older [DEPTH];   // older[i][j]: entry i was dispatched before entry j
    logic [3:0]        e_op  [DEPTH];
    logic [TAG_W-1:0]  e_dest[DEPTH];
    logic [TAG_W-1:0]  e_tag1[DEPTH];
    logic [TAG_W-1:0]  e_tag2[DEPTH];
    logic [DATA_W-1:0] e_d1  [DEPTH];
    logic [DATA_W-1:0] e_d2  [DEPTH];
    logic [DATA_W-1:0] e_pc  [DEPTH];

    logic [TAG_W-1:0]  w_tag1[DEPTH];
    logic [TAG_W-1:0]  w_tag2[DEPTH];
    logic [DATA_W-1:0] w_d1  [DEPTH];
    logic [DATA_W-1:0] w_d2  [DEPTH];

    logic [TAG_W-1:0]  n_tag1, n_tag2;
    logic [DATA_W-1:0] n_d1, n_d2;
    logic [DEPTH-1:0]  rdy;
    logic [IW-1:0]     alloc_idx, sel;
    logic              found, dispatch, issue;
    logic [DATA_W-1:0] ex_a, ex_b, ex_sum, ex_res, ex_tgt;
    logic              ex_jmp;

    assign in_ready = (count < CW'(DEPTH));
    assign dispatch = in_valid && in_ready && !flush && (in_op != 4'd0) && (in_op <= OP_JALR);

    // Lowest port wins: scan from the highest port down so lower ports overwrite.
    always_comb begin
        n_tag1 = in_tag1;
        n_tag2 = in_tag2;
        n_d1   = in_data1;
        n_d2   = in_data2;
        for (int p = NCDB - 1; p >= 0; p--) begin
            if (cdb_valid[p] && in_tag1 != '0 && in_tag1 == cdb_tag[p*TAG_W +: TAG_W]) begin
                n_tag1 = '0;
                n_d1   = cdb_data[p*DATA_W +: DATA_W];
            end
            if (cdb_valid[p] && in_tag2 != '0 && in_tag2 == cdb_tag[p*TAG_W +: TAG_W]) begin
                n_tag2 = '0;
                n_d2   = cdb_data[p*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_tag1[i] = e_tag1[i];
            w_tag2[i] = e_tag2[i];
            w_d1[i]   = e_d1[i];
            w_d2[i]   = e_d2[i];
            for (int p = NCDB - 1; p >= 0; p--) begin
                if (cdb_valid[p] && e_tag1[i] != '0 && e_tag1[i] == cdb_tag[p*TAG_W +: TAG_W]) begin
                    w_tag1[i] = '0;
                    w_d1[i]   = cdb_data[p*DATA_W +: DATA_W];
                end
                if (cdb_valid[p] && e_tag2[i] != '0 && e_tag2[i] == cdb_tag[p*TAG_W +: TAG_W]) begin
                    w_tag2[i] = '0;
                    w_d2[i]   = cdb_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!occ[i]) alloc_idx = IW'(i);
        end
    end

    // An entry is oldest-ready when no other ready entry is older than it.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = occ[i] && e_tag1[i] == '0 && e_tag2[i] == '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            logic cand;
            cand = rdy[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && rdy[j] && older[j][i]) cand = 1'b0;
            end
            if (cand && !found) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
    end

    assign issue = found && (!out_valid || out_ready) && !flush;

    always_comb begin
        ex_a   = e_d1[sel];
        ex_b   = e_d2[sel];
        ex_sum = ex_a + ex_b;
        ex_res = '0;
        ex_tgt = '0;
        ex_jmp = 1'b0;
        case (e_op[sel])
            OP_ADD:  ex_res = ex_sum;
            OP_SUB:  ex_res = ex_a - ex_b;
            OP_SLL:  ex_res = ex_a << ex_b[SW-1:0];
            OP_SLT:  ex_res = {{(DATA_W-1){1'b0}}, $signed(ex_a) < $signed(ex_b)};
            OP_SLTU: ex_res = {{(DATA_W-1){1'b0}}, ex_a < ex_b};
            OP_XOR:  ex_res = ex_a ^ ex_b;
            OP_SRL:  ex_res = ex_a >> ex_b[SW-1:0];
            OP_SRA:  ex_res = $unsigned($signed(ex_a) >>> ex_b[SW-1:0]);
            OP_OR:   ex_res = ex_a | ex_b;
            OP_AND:  ex_res = ex_a & ex_b;
            OP_LUI:  ex_res = ex_b;
            OP_JAL: begin
                ex_res = e_pc[sel] + DATA_W'(4);
                ex_tgt = ex_sum;
                ex_jmp = 1'b1;
            end
            OP_JALR: begin
                ex_res = e_pc[sel] + DATA_W'(4);
                ex_tgt = ex_sum & ~DATA_W'(1);
                ex_jmp = 1'b1;
            end
            default: ex_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older[i]  <= '0;
                e_op[i]   <= '0;
                e_dest[i] <= '0;
                e_tag1[i] <= '0;
                e_tag2[i] <= '0;
                e_d1[i]   <= '0;
                e_d2[i]   <= '0;
                e_pc[i]   <= '0;
            end
        end else if (flush) begin
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (occ[i]) begin
                    e_tag1[i] <= w_tag1[i];
                    e_tag2[i] <= w_tag2[i];
                    e_d1[i]   <= w_d1[i];
                    e_d2[i]   <= w_d2[i];
                end
            end
            if (issue) occ[sel] <= 1'b0;
            if (dispatch) begin
                occ[alloc_idx]    <= 1'b1;
                e_op[alloc_idx]   <= in_op;
                e_dest[alloc_idx] <= in_dest;
                e_tag1[alloc_idx] <= n_tag1;
                e_tag2[alloc_idx] <= n_tag2;
                e_d1[alloc_idx]   <= n_d1;
                e_d2[alloc_idx]   <= n_d2;
                e_pc[alloc_idx]   <= in_pc;
                older[alloc_idx]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (IW'(j) != alloc_idx) older[j][alloc_idx] <= occ[j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count + CW'(dispatch) - CW'(issue);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_tag      <= '0;
            out_data     <= '0;
            out_target   <= '0;
            out_pc_valid <= 1'b0;
        end else if (flush || (!issue && out_valid && out_ready)) begin
            out_valid    <= 1'b0;
            out_tag      <= '0;
            out_data     <= '0;
            out_target   <= '0;
            out_pc_valid <= 1'b0;
        end else if (issue) begin
            out_valid    <= 1'b1;
            out_tag      <= e_dest[sel];
            out_data     <= ex_res;
            out_target   <= ex_tgt;
            out_pc_valid <= ex_jmp;
        end
    end
endmodule

// File: tb/tb_alu_rs_pipe.sv
// Directed bench for alu_rs_pipe: dispatch, wakeup, ordering, backpressure, execute, flush, reset.
module tb_alu_rs_pipe;
    localparam int DW = 32, TW = 5, D = 8, NC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [TW-1:0] in_dest, in_tag1, in_tag2;
    logic [DW-1:0] in_data1, in_data2, in_pc;
    logic [NC-1:0] cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*DW-1:0] cdb_data;
    logic          out_valid, out_ready, out_pc_valid;
    logic [TW-1:0] out_tag;
    logic [DW-1:0] out_data, out_target;
    logic [3:0]    count;

    int total = 0;
    int bad   = 0;

    logic [3:0]  v_op  [8];
    logic [31:0] v_d1  [8];
    logic [31:0] v_d2  [8];
    logic [31:0] v_pc  [8];
    logic [31:0] v_dat [8];
    logic [31:0] v_tgt [8];
    logic        v_pcv [8];

    alu_rs_pipe #(.DATA_W(DW), .TAG_W(TW), .DEPTH(D), .NCDB(NC)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_dest(in_dest),
        .in_tag1(in_tag1), .in_tag2(in_tag2), .in_data1(in_data1), .in_data2(in_data2),
        .in_pc(in_pc), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
        .out_target(out_target), .out_pc_valid(out_pc_valid), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [4:0] dest, input logic [4:0] t1,
                         input logic [4:0] t2, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] pc);
        in_valid = 1'b1; in_op = op; in_dest = dest; in_tag1 = t1; in_tag2 = t2;
        in_data1 = d1; in_data2 = d2; in_pc = pc;
    endtask

    initial begin
        v_op[0] = 4'd13; v_d1[0] = 32'h1001;     v_d2[0] = 32'h4;        v_pc[0] = 32'h200; v_dat[0] = 32'h204;      v_tgt[0] = 32'h1004; v_pcv[0] = 1'b1;
        v_op[1] = 4'd8;  v_d1[1] = 32'h80000000; v_d2[1] = 32'h21;       v_pc[1] = 32'h0;   v_dat[1] = 32'hC0000000; v_tgt[1] = 32'h0;    v_pcv[1] = 1'b0;
        v_op[2] = 4'd12; v_d1[2] = 32'h100;      v_d2[2] = 32'h20;       v_pc[2] = 32'h40;  v_dat[2] = 32'h44;       v_tgt[2] = 32'h120;  v_pcv[2] = 1'b1;
        v_op[3] = 4'd4;  v_d1[3] = 32'hFFFFFFFF; v_d2[3] = 32'h1;        v_pc[3] = 32'h0;   v_dat[3] = 32'h1;        v_tgt[3] = 32'h0;    v_pcv[3] = 1'b0;
        v_op[4] = 4'd5;  v_d1[4] = 32'hFFFFFFFF; v_d2[4] = 32'h1;        v_pc[4] = 32'h0;   v_dat[4] = 32'h0;        v_tgt[4] = 32'h0;    v_pcv[4] = 1'b0;
        v_op[5] = 4'd3;  v_d1[5] = 32'h1;        v_d2[5] = 32'h24;       v_pc[5] = 32'h0;   v_dat[5] = 32'h10;       v_tgt[5] = 32'h0;    v_pcv[5] = 1'b0;
        v_op[6] = 4'd7;  v_d1[6] = 32'h80000000; v_d2[6] = 32'h4;        v_pc[6] = 32'h0;   v_dat[6] = 32'h08000000; v_tgt[6] = 32'h0;    v_pcv[6] = 1'b0;
        v_op[7] = 4'd11; v_d1[7] = 32'hDEAD;     v_d2[7] = 32'h12345000; v_pc[7] = 32'h0;   v_dat[7] = 32'h12345000; v_tgt[7] = 32'h0;    v_pcv[7] = 1'b0;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0; in_dest = '0;
        in_tag1 = '0; in_tag2 = '0; in_data1 = '0; in_data2 = '0; in_pc = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; out_ready = 1'b1;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'd0);
        #10 rst = 1'b1;
        tick();

        // Simple ADD: 2-edge latency.
        drive(4'd1, 5'd3, 5'd0, 5'd0, 32'd5, 32'd7, 32'd0);
        tick();
        in_valid = 1'b0;
        check("add_count_after_dispatch", 32'(count), 32'd1);
        check("add_not_yet_valid", 32'(out_valid), 32'd0);
        check("add_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_out_tag", 32'(out_tag), 32'd3);
        check("add_out_data", out_data, 32'd12);
        check("add_pc_valid", 32'(out_pc_valid), 32'd0);
        check("add_count_after_issue", 32'(count), 32'd0);
        tick();
        check("add_result_cleared", 32'(out_valid), 32'd0);

        // NOP and ops 14-15 are dropped.
        drive(4'd0, 5'd9, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0);
        tick();
        drive(4'd15, 5'd9, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        check("nop_count", 32'(count), 32'd0);
        tick();
        check("nop_no_result", 32'(out_valid), 32'd0);

        // Multi-port wakeup.
        drive(4'd2, 5'd1, 5'd4, 5'd6, 32'd0, 32'd0, 32'd0);
        tick();
        in_valid = 1'b0;
        cdb_valid = 2'b11; cdb_tag = {5'd6, 5'd4}; cdb_data = {32'd30, 32'd100};
        tick();
        cdb_valid = '0;
        check("wake_not_same_edge", 32'(out_valid), 32'd0);
        tick();
        check("wake_sub_valid", 32'(out_valid), 32'd1);
        check("wake_sub_data", out_data, 32'd70);
        check("wake_sub_tag", 32'(out_tag), 32'd1);

        // Both ports carry the same tag: port 0 wins.
        drive(4'd2, 5'd2, 5'd4, 5'd0, 32'd0, 32'd1, 32'd0);
        tick();
        in_valid = 1'b0;
        cdb_valid = 2'b11; cdb_tag = {5'd4, 5'd4}; cdb_data = {32'd8, 32'd9};
        tick();
        cdb_valid = '0;
        tick();
        check("port0_priority_data", out_data, 32'd8);

        // Dispatch bypass from the CDB in the dispatch cycle.
        drive(4'd1, 5'd4, 5'd7, 5'd0, 32'd0, 32'd3, 32'd0);
        cdb_valid = 2'b10; cdb_tag = {5'd7, 5'd0}; cdb_data = {32'd40, 32'd0};
        tick();
        in_valid = 1'b0; cdb_valid = '0;
        tick();
        check("bypass_data", out_data, 32'd43);
        check("bypass_tag", 32'(out_tag), 32'd4);
        tick();

        // Fill to DEPTH; only the youngest entry is ready.
        for (int i = 0; i < 8; i++) begin
            if (i < 7) drive(4'd1, 5'(16 + i), 5'(8 + i), 5'd0, 32'd0, 32'(i), 32'd0);
            else       drive(4'd1, 5'd23, 5'd0, 5'd0, 32'd70, 32'd7, 32'd0);
            tick();
        end
        check("full_count", 32'(count), 32'd8);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_no_result_yet", 32'(out_valid), 32'd0);
        drive(4'd1, 5'd30, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0);
        cdb_valid = 2'b11; cdb_tag = {5'd13, 5'd10}; cdb_data = {32'd200, 32'd100};
        tick();
        in_valid = 1'b0; cdb_valid = '0;
        check("full_dispatch_ignored_count", 32'(count), 32'd7);
        check("oldest_first_tag0", 32'(out_tag), 32'd23);
        check("oldest_first_data0", out_data, 32'd77);
        tick();
        check("oldest_first_tag1", 32'(out_tag), 32'd18);
        check("oldest_first_data1", out_data, 32'd102);
        check("oldest_first_count1", 32'(count), 32'd6);
        tick();
        check("oldest_first_tag2", 32'(out_tag), 32'd21);
        check("oldest_first_data2", out_data, 32'd205);
        check("oldest_first_count2", 32'(count), 32'd5);

        // Hold the result, then flush with 5 waiting entries.
        out_ready = 1'b0;
        tick();
        check("held_valid", 32'(out_valid), 32'd1);
        check("held_data", out_data, 32'd205);
        check("held_count", 32'(count), 32'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd8}; cdb_data = {32'd0, 32'd1};
        tick();
        cdb_valid = '0;
        tick();
        check("flush_no_ghost_issue", 32'(out_valid), 32'd0);

        // Backpressure: one result held, three ready entries wait.
        drive(4'd1,  5'd1, 5'd0, 5'd0, 32'd1,    32'd1,    32'd0); tick();
        drive(4'd6,  5'd2, 5'd0, 5'd0, 32'hF0,   32'h0F,   32'd0); tick();
        drive(4'd10, 5'd3, 5'd0, 5'd0, 32'hFF,   32'h3C,   32'd0); tick();
        drive(4'd2,  5'd4, 5'd0, 5'd0, 32'd5,    32'd7,    32'd0); tick();
        in_valid = 1'b0;
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_data", out_data, 32'd2);
        check("bp_count", 32'(count), 32'd3);
        tick(); tick();
        check("bp_still_valid", 32'(out_valid), 32'd1);
        check("bp_stable_data", out_data, 32'd2);
        check("bp_stable_count", 32'(count), 32'd3);
        out_ready = 1'b1;
        tick();
        check("bp_rel_data0", out_data, 32'hFF);
        check("bp_rel_count0", 32'(count), 32'd2);
        tick();
        check("bp_rel_data1", out_data, 32'h3C);
        tick();
        check("bp_rel_data2", out_data, 32'hFFFFFFFE);
        check("bp_rel_tag2", 32'(out_tag), 32'd4);
        check("bp_rel_count2", 32'(count), 32'd0);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Execute vectors, back-to-back.
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) drive(v_op[k], 5'(k + 1), 5'd0, 5'd0, v_d1[k], v_d2[k], v_pc[k]);
            else       in_valid = 1'b0;
            tick();
            if (k >= 1) begin
                check($sformatf("vec%0d_valid", k - 1), 32'(out_valid), 32'd1);
                check($sformatf("vec%0d_tag", k - 1), 32'(out_tag), 32'(k));
                check($sformatf("vec%0d_data", k - 1), out_data, v_dat[k-1]);
                check($sformatf("vec%0d_target", k - 1), out_target, v_tgt[k-1]);
                check($sformatf("vec%0d_pcv", k - 1), 32'(out_pc_valid), 32'(v_pcv[k-1]));
            end
        end
        tick();

        // Asynchronous reset mid-operation.
        out_ready = 1'b0;
        drive(4'd12, 5'd6, 5'd0, 5'd0, 32'd2, 32'd3, 32'h10); tick();
        drive(4'd1,  5'd7, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0);  tick();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_count", 32'(count), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_out_tag", 32'(out_tag), 32'd0);
        check("arst_out_target", out_target, 32'd0);
        check("arst_pc_valid", 32'(out_pc_valid), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        tick(); tick();
        check("post_rst_empty", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
